// File: rtl/uart_tx.sv
// UART transmitter: AXI-stream byte in, 8N1/8E1/8O1 (1 or 2 stop) frame out, optional input FIFO.
// Bit edges follow a fractional accumulator so long frames never drift from the ideal baud grid.
module uart_tx #(
  parameter int unsigned CLK_FREQ  = 50000000,
  parameter int unsigned BAUD_RATE = 115200,
  parameter string       PARITY    = "NONE",
  parameter int unsigned STOP_BITS = 1,
  parameter int unsigned FIFO_EA   = 0
) (
  input  logic       rstn,
  input  logic       clk,
  input  logic       i_tvalid,
  output logic       i_tready,
  input  logic [7:0] i_tdata,
  output logic       o_uart_tx,
  output logic       o_busy
);

  localparam int unsigned BAUD_CYCLES = CLK_FREQ / BAUD_RATE;
  localparam logic [31:0] FRAC_STEP   = 32'(2 * (CLK_FREQ % BAUD_RATE));
  localparam logic [31:0] FRAC_WRAP   = 32'(2 * BAUD_RATE);
  localparam logic [31:0] FRAC_INIT   = 32'(BAUD_RATE);
  localparam bit          PAR_EN      = (PARITY != "NONE");
  localparam bit          PAR_ODD     = (PARITY == "ODD");
  localparam int unsigned NBITS       = 10 + (PAR_EN ? 1 : 0) + STOP_BITS - 1;
  localparam int unsigned CW          = $clog2(BAUD_CYCLES + 2);
  localparam logic [3:0]  LAST_BIT    = 4'(NBITS - 1);

  if (BAUD_CYCLES < 10) begin : g_baud_chk
    $error("uart_tx: CLK_FREQ/BAUD_RATE must be at least 10");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_stop_chk
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [0:0] {StIdle, StTx} state_e;

  state_e          state_q;
  logic [10:0]     shift_q;
  logic [3:0]      bit_q;
  logic [CW-1:0]   cnt_q;
  logic [31:0]     frac_q;
  logic            tx_q;
  logic            busy_q;

  logic            load;
  logic [7:0]      load_data;
  logic            fifo_ne_d;
  logic [31:0]     frac_src, frac_sum, frac_nxt;
  logic            carry;
  logic [CW-1:0]   len_m1;
  logic [11:0]     frame;

  // Accumulator holds (BAUD_RATE + k*2*(CLK_FREQ mod BAUD_RATE)) mod 2*BAUD_RATE, which
  // gives round-half-up bit edges; a carry stretches the next bit by one cycle.
  always_comb begin
    frac_src = (state_q == StIdle) ? FRAC_INIT : frac_q;
    frac_sum = frac_src + FRAC_STEP;
    carry    = (frac_sum >= FRAC_WRAP);
    frac_nxt = carry ? frac_sum - FRAC_WRAP : frac_sum;
    len_m1   = CW'(BAUD_CYCLES - 1) + CW'(carry);
  end

  always_comb begin
    frame      = '1;
    frame[0]   = 1'b0;
    frame[8:1] = load_data;
    if (PAR_EN) frame[9] = PAR_ODD ? ~^load_data : ^load_data;
  end

  if (FIFO_EA == 0) begin : g_direct
    assign i_tready  = (state_q == StIdle);
    assign load      = i_tvalid & (state_q == StIdle);
    assign load_data = i_tdata;
    assign fifo_ne_d = 1'b0;
  end else begin : g_fifo
    localparam int unsigned AW    = (FIFO_EA < 2) ? 2 : FIFO_EA;
    localparam int unsigned DEPTH = 1 << AW;
    localparam logic [AW:0] PTR_ONE = 1;

    logic [7:0]  mem_q [DEPTH];
    logic [AW:0] wr_q, rd_q, wr_d, rd_d;
    logic        rdy_q, full, empty, push, pop;

    assign full      = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign empty     = (wr_q == rd_q);
    // Ready stays low until the first clock after reset release.
    assign i_tready  = rdy_q & ~full;
    assign push      = i_tvalid & i_tready;
    assign pop       = (state_q == StIdle) & ~empty;
    assign wr_d      = push ? wr_q + PTR_ONE : wr_q;
    assign rd_d      = pop ? rd_q + PTR_ONE : rd_q;
    assign load      = pop;
    assign load_data = mem_q[rd_q[AW-1:0]];
    assign fifo_ne_d = (wr_d != rd_d);

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        wr_q  <= '0;
        rd_q  <= '0;
        rdy_q <= 1'b0;
      end else begin
        wr_q  <= wr_d;
        rd_q  <= rd_d;
        rdy_q <= 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (push) mem_q[wr_q[AW-1:0]] <= i_tdata;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      shift_q <= '1;
      bit_q   <= '0;
      cnt_q   <= '0;
      frac_q  <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      busy_q <= load | (state_q == StTx) | fifo_ne_d;
      unique case (state_q)
        StIdle: begin
          if (load) begin
            state_q <= StTx;
            tx_q    <= frame[0];
            shift_q <= frame[11:1];
            bit_q   <= '0;
            cnt_q   <= len_m1;
            frac_q  <= frac_nxt;
          end
        end
        StTx: begin
          // Leave one cycle early so the next frame can load during the final stop cycle.
          if (bit_q == LAST_BIT && cnt_q == CW'(1)) begin
            state_q <= StIdle;
            cnt_q   <= cnt_q - CW'(1);
          end else if (cnt_q == '0) begin
            tx_q    <= shift_q[0];
            shift_q <= {1'b1, shift_q[10:1]};
            bit_q   <= bit_q + 4'd1;
            cnt_q   <= len_m1;
            frac_q  <= frac_nxt;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign o_uart_tx = tx_q;
  assign o_busy    = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: several parameterisations share one clock and reset,
// line traces are captured on negedges and compared against hand-derived frames.
module tb_uart_tx;

  logic       clk, rstn;
  logic       tvalid [6];
  logic [7:0] tdata  [6];
  logic       tready [6];
  logic       line   [6];
  logic       busy   [6];

  int   checks, errors;
  logic trace_l [4096];
  logic trace_r [4096];
  logic trace_b [4096];
  int   bnd [12];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  uart_tx #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .PARITY("NONE"), .STOP_BITS(1),
            .FIFO_EA(0)) u_none (
    .rstn(rstn), .clk(clk), .i_tvalid(tvalid[0]), .i_tready(tready[0]), .i_tdata(tdata[0]),
    .o_uart_tx(line[0]), .o_busy(busy[0]));

  uart_tx #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .PARITY("EVEN"), .STOP_BITS(1),
            .FIFO_EA(0)) u_even (
    .rstn(rstn), .clk(clk), .i_tvalid(tvalid[1]), .i_tready(tready[1]), .i_tdata(tdata[1]),
    .o_uart_tx(line[1]), .o_busy(busy[1]));

  uart_tx #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .PARITY("ODD"), .STOP_BITS(1),
            .FIFO_EA(0)) u_odd (
    .rstn(rstn), .clk(clk), .i_tvalid(tvalid[2]), .i_tready(tready[2]), .i_tdata(tdata[2]),
    .o_uart_tx(line[2]), .o_busy(busy[2]));

  uart_tx #(.CLK_FREQ(1000000), .BAUD_RATE(30000), .PARITY("NONE"), .STOP_BITS(1),
            .FIFO_EA(0)) u_frac (
    .rstn(rstn), .clk(clk), .i_tvalid(tvalid[3]), .i_tready(tready[3]), .i_tdata(tdata[3]),
    .o_uart_tx(line[3]), .o_busy(busy[3]));

  uart_tx #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .PARITY("NONE"), .STOP_BITS(1),
            .FIFO_EA(2)) u_fifo (
    .rstn(rstn), .clk(clk), .i_tvalid(tvalid[4]), .i_tready(tready[4]), .i_tdata(tdata[4]),
    .o_uart_tx(line[4]), .o_busy(busy[4]));

  uart_tx #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .PARITY("ODD"), .STOP_BITS(2),
            .FIFO_EA(0)) u_odd2 (
    .rstn(rstn), .clk(clk), .i_tvalid(tvalid[5]), .i_tready(tready[5]), .i_tdata(tdata[5]),
    .o_uart_tx(line[5]), .o_busy(busy[5]));

  task automatic run_trace(input int idx, input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      trace_l[c] = line[idx];
      trace_r[c] = tready[idx];
      trace_b[c] = busy[idx];
      @(negedge clk);
    end
  endtask

  // Handshake in one cycle; returns at the negedge of the first cycle after it.
  task automatic send_one(input int idx, input logic [7:0] d);
    @(negedge clk);
    checks++;
    if (tready[idx] !== 1'b1) begin
      errors++;
      $display("FAIL ready_idle[%0d]: tready=%b, required 1", idx, tready[idx]);
    end
    tvalid[idx] = 1'b1;
    tdata[idx]  = d;
    @(negedge clk);
    tvalid[idx] = 1'b0;
    tdata[idx]  = ~d;
  endtask

  task automatic check_frame(input string name, input int nb, input logic [11:0] bits);
    int   s, e;
    logic bad, act;
    for (int k = 0; k < nb; k++) begin
      s   = (k == 0) ? 0 : bnd[k-1];
      e   = bnd[k];
      bad = 1'b0;
      act = bits[k];
      for (int c = s; c < e; c++) begin
        if (trace_l[c] !== bits[k]) begin
          bad = 1'b1;
          act = trace_l[c];
        end
      end
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL %s bit%0d: line=%b in cycles %0d..%0d, required %b",
                 name, k, act, s, e - 1, bits[k]);
      end
    end
    e = bnd[nb-1];
    checks++;
    if (trace_l[e] !== 1'b1) begin
      errors++;
      $display("FAIL %s idle_after: line=%b at cycle %0d, required 1", name, trace_l[e], e);
    end
    bad = (trace_b[e] !== 1'b0);
    for (int c = 0; c < e; c++) if (trace_b[c] !== 1'b1) bad = 1'b1;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL %s busy: busy not high for cycles 0..%0d then low at %0d (end=%b)",
               name, e - 1, e, trace_b[e]);
    end
    bad = (trace_r[e-1] !== 1'b1);
    for (int c = 0; c < e - 1; c++) if (trace_r[c] !== 1'b0) bad = 1'b1;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL %s ready: tready not low for 0..%0d then high at %0d (got %b)",
               name, e - 2, e - 1, trace_r[e-1]);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tvalid[i] = 1'b0;
      tdata[i]  = 8'h00;
    end
    repeat (3) @(negedge clk);
    checks += 5;
    if (line[0] !== 1'b1) begin errors++; $display("FAIL rst_line: %b, required 1", line[0]); end
    if (busy[0] !== 1'b0) begin errors++; $display("FAIL rst_busy: %b, required 0", busy[0]); end
    if (tready[0] !== 1'b1) begin
      errors++; $display("FAIL rst_ready_nofifo: %b, required 1", tready[0]);
    end
    if (tready[4] !== 1'b0) begin
      errors++; $display("FAIL rst_ready_fifo: %b, required 0", tready[4]);
    end
    if (line[4] !== 1'b1) begin errors++; $display("FAIL rst_line_fifo: %b, required 1", line[4]); end
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if (tready[4] !== 1'b1) begin
      errors++; $display("FAIL post_rst_ready_fifo: %b, required 1", tready[4]);
    end
  endtask

  task automatic test_basic_frame();
    for (int k = 0; k < 12; k++) bnd[k] = 10 * (k + 1);
    send_one(0, 8'h55);
    run_trace(0, 110);
    check_frame("none_55", 10, {2'b11, 1'b1, 8'h55, 1'b0});
  endtask

  task automatic test_parity();
    for (int k = 0; k < 12; k++) bnd[k] = 10 * (k + 1);
    send_one(1, 8'h07);
    run_trace(1, 120);
    check_frame("even_07", 11, {2'b11, 1'b1, 8'h07, 1'b0});
    send_one(2, 8'h07);
    run_trace(2, 120);
    check_frame("odd_07", 11, {2'b11, 1'b0, 8'h07, 1'b0});
  endtask

  task automatic test_frac_timing();
    bnd = '{33, 67, 100, 133, 167, 200, 233, 267, 300, 333, 0, 0};
    send_one(3, 8'hA3);
    run_trace(3, 345);
    check_frame("frac_a3", 10, {2'b11, 1'b1, 8'hA3, 1'b0});
  endtask

  task automatic test_fifo_burst();
    int          n;
    int          acc [6];
    logic [11:0] fb;
    logic        bad;
    int          k;
    n = 0;
    for (int i = 0; i < 6; i++) acc[i] = -1;
    @(negedge clk);
    for (int c = 0; c < 620; c++) begin
      tvalid[4]  = (n < 6);
      tdata[4]   = (n < 6) ? 8'(n + 1) : 8'h00;
      trace_l[c] = line[4];
      trace_r[c] = tready[4];
      trace_b[c] = busy[4];
      if (tvalid[4] && tready[4]) begin
        acc[n] = c;
        n++;
      end
      @(negedge clk);
    end
    tvalid[4] = 1'b0;
    checks++;
    if (acc[0] != 0 || acc[1] != 1 || acc[2] != 2 || acc[3] != 3 || acc[4] != 4) begin
      errors++;
      $display("FAIL fifo_accepts: cycles %0d %0d %0d %0d %0d, required 0 1 2 3 4",
               acc[0], acc[1], acc[2], acc[3], acc[4]);
    end
    checks++;
    if (trace_r[5] !== 1'b0) begin
      errors++; $display("FAIL fifo_full_ready: tready=%b at cycle 5, required 0", trace_r[5]);
    end
    checks++;
    if (acc[5] != 102) begin
      errors++; $display("FAIL fifo_recover: 6th accept at %0d, required 102", acc[5]);
    end
    for (int f = 0; f < 6; f++) begin
      fb  = {3'b111, 8'(f + 1), 1'b0};
      bad = 1'b0;
      for (int c = 2 + 100 * f; c < 102 + 100 * f; c++) begin
        k = (c - 2 - 100 * f) / 10;
        if (trace_l[c] !== fb[k]) bad = 1'b1;
      end
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL fifo_frame%0d: line differs from byte %0d frame in cycles %0d..%0d",
                 f, f + 1, 2 + 100 * f, 101 + 100 * f);
      end
    end
    bad = (trace_b[0] !== 1'b0) || (trace_b[602] !== 1'b0) || (trace_l[602] !== 1'b1);
    for (int c = 1; c < 602; c++) if (trace_b[c] !== 1'b1) bad = 1'b1;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL fifo_busy: busy@0=%b busy@602=%b line@602=%b, required 0 0 1",
               trace_b[0], trace_b[602], trace_l[602]);
    end
  endtask

  task automatic test_reset_midframe();
    int   n;
    logic bad;
    n = 0;
    @(negedge clk);
    for (int c = 0; c < 45; c++) begin
      tvalid[4] = (n < 3);
      tdata[4]  = (n == 0) ? 8'hFF : ((n == 1) ? 8'h11 : 8'h22);
      if (tvalid[4] && tready[4]) n++;
      @(negedge clk);
    end
    tvalid[4] = 1'b0;
    checks++;
    if (n != 3 || busy[4] !== 1'b1) begin
      errors++; $display("FAIL midrst_setup: accepted=%0d busy=%b, required 3 1", n, busy[4]);
    end
    rstn = 1'b0;
    #1;
    checks++;
    if (line[4] !== 1'b1 || busy[4] !== 1'b0 || tready[4] !== 1'b0) begin
      errors++;
      $display("FAIL midrst_async: line=%b busy=%b tready=%b, required 1 0 0",
               line[4], busy[4], tready[4]);
    end
    @(negedge clk);
    rstn = 1'b1;
    bad = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (line[4] !== 1'b1 || busy[4] !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++; $display("FAIL midrst_quiet: line or busy active after reset, required 1 / 0");
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  rb [32];
    logic [11:0] v;
    int          n, p, got;
    int          rx_st [32];
    logic [11:0] rx_v [32];
    logic        bad;
    for (int i = 0; i < 32; i++) rb[i] = 8'($urandom_range(0, 255));
    n = 0;
    @(negedge clk);
    for (int c = 0; c < 3900; c++) begin
      trace_l[c] = line[5];
      if (n < 32 && tready[5] === 1'b1) begin
        tvalid[5] = 1'b1;
        tdata[5]  = rb[n];
        n++;
      end else begin
        tvalid[5] = 1'b0;
        tdata[5]  = 8'h00;
      end
      @(negedge clk);
    end
    tvalid[5] = 1'b0;
    // Software receiver: falling edge marks a start bit, sample at mid-bit.
    p   = 0;
    got = 0;
    while (p < 3780 && got < 32) begin
      if (trace_l[p] === 1'b0) begin
        for (int k = 0; k < 12; k++) v[k] = trace_l[p + 5 + 10 * k];
        rx_st[got] = p;
        rx_v[got]  = v;
        got++;
        p += 115;
      end else begin
        p++;
      end
    end
    checks++;
    if (got != 32 || n != 32) begin
      errors++; $display("FAIL loop_count: sent=%0d received=%0d, required 32 32", n, got);
    end
    for (int i = 0; i < got; i++) begin
      v = rx_v[i];
      checks++;
      if (v[0] !== 1'b0 || v[8:1] !== rb[i] || (^v[9:1]) !== 1'b1 || v[11:10] !== 2'b11) begin
        errors++;
        $display("FAIL loop_byte%0d: frame=%b, required data %h odd parity 2 stops",
                 i, v, rb[i]);
      end
    end
    bad = 1'b0;
    for (int i = 1; i < got; i++) if (rx_st[i] - rx_st[i-1] != 120) bad = 1'b1;
    checks++;
    if (bad) begin
      errors++; $display("FAIL loop_gapless: frame starts not spaced by 120 cycles");
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic_frame();
    test_parity();
    test_frac_timing();
    test_fifo_burst();
    test_reset_midframe();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
